act_fetch_unit: RTL and testbench

Parametrised activation row buffer with sparse serial and dense parallel read-out. It sits between the activation loader and the PE array. The loader writes whole rows, each a flag vector plus NCH data words, into an internal row FIFO. The unit then emits each row in one of two forms:
- mode 0: only the non-zero elements, one per cycle, with their channel index, under a valid/ready handshake;
- mode 1: the full row in parallel, also under a valid/ready handshake.

---
 rtl/act_pkg.sv | 16 +
 rtl/flag_index_scan.sv | 19 +
 rtl/act_fetch_unit.sv | 124 ++++++++++++
 tb/tb_act_fetch_unit.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/act_pkg.sv
// act_pkg: shared FSM state type, default sizes and popcount helper for act_fetch_unit
// Contents: fsm_t (IDLE/LOAD/SCAN/PAR), DEF_* size defaults, MAX_NCH, popcount().
package act_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NCH = 16;
  localparam int DEF_DEPTH = 32;
  // popcount works on a fixed-width vector; callers zero-extend their flags to this width
  localparam int MAX_NCH = 64;
  typedef enum logic [1:0] {IDLE, LOAD, SCAN, PAR} fsm_t;
  function automatic int unsigned popcount(input logic [MAX_NCH-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_NCH; i++) c = c + {31'b0, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/flag_index_scan.sv
// flag_index_scan: combinational lowest-set-bit finder over a channel mask
// Ports: mask (in, NCH) remaining channels; idx (out) lowest set index;
//        onehot (out) that bit isolated; single (out) exactly one bit set.
module flag_index_scan #(
  parameter int NCH = 16,
  parameter int IDX_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   mask,
  output logic [IDX_W-1:0] idx,
  output logic [NCH-1:0]   onehot,
  output logic             single
);
  always_comb begin
    idx = '0;
    for (int i = NCH - 1; i >= 0; i--) if (mask[i]) idx = IDX_W'(i);
    onehot = mask & (~mask + NCH'(1));
    single = (mask != '0) && ((mask & (mask - NCH'(1))) == '0);
  end
endmodule

// File: rtl/act_fetch_unit.sv
// act_fetch_unit: activation row FIFO with sparse serial and dense parallel read-out
// Ports: clk, reset (async, active-low), clear (sync flush), mode (0 sparse / 1 dense);
//        write side wr_en/wr_flag/wr_data with full/empty/overflow status;
//        serial side s_valid/s_ready/s_data/s_idx/s_last;
//        parallel side p_valid/p_ready/p_data/p_flag; row_nnz and row_done per row.
module act_fetch_unit
  import act_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NCH = DEF_NCH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = $clog2(NCH),
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  mode,
  input  logic                  wr_en,
  input  logic [NCH-1:0]        wr_flag,
  input  logic [NCH*DATA_W-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  s_valid,
  input  logic                  s_ready,
  output logic [DATA_W-1:0]     s_data,
  output logic [IDX_W-1:0]      s_idx,
  output logic                  s_last,
  output logic                  p_valid,
  input  logic                  p_ready,
  output logic [NCH*DATA_W-1:0] p_data,
  output logic [NCH-1:0]        p_flag,
  output logic [IDX_W:0]        row_nnz,
  output logic                  row_done
);
  logic [NCH-1:0]        mem_flag [DEPTH];
  logic [NCH*DATA_W-1:0] mem_data [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr, rd_ptr;
  logic [ADDR_W:0]       count;
  fsm_t                  state, nxt;
  logic [NCH-1:0]        row_flag, mask, clr;
  logic [NCH*DATA_W-1:0] row_data;
  logic [IDX_W-1:0]      idx;
  logic                  single, wr_ok, pop, row_empty;

  flag_index_scan #(.NCH(NCH), .IDX_W(IDX_W)) u_scan (
    .mask(mask),
    .idx(idx),
    .onehot(clr),
    .single(single)
  );

  assign full = count == (ADDR_W+1)'(DEPTH);
  assign empty = count == '0;
  // full is taken from the registered count, so a same-cycle pop never frees a slot
  assign wr_ok = wr_en && !full && !clear;
  assign row_empty = row_nnz == '0;
  assign s_idx = idx;
  assign s_data = row_data[idx*DATA_W +: DATA_W];
  assign p_data = row_data;
  assign p_flag = row_flag;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = empty ? IDLE : LOAD;
      LOAD: nxt = mode ? PAR : row_empty ? IDLE : SCAN;
      SCAN: nxt = (s_ready && single) ? IDLE : SCAN;
      PAR:  nxt = p_ready ? IDLE : PAR;
      default: nxt = IDLE;
    endcase
    if (clear) nxt = IDLE;
  end

  always_comb begin
    s_valid = state == SCAN;
    p_valid = state == PAR;
    s_last = s_valid && single;
    // a sparse all-zero row retires straight from LOAD without emitting anything
    pop = !clear && ((state == LOAD && !mode && row_empty) || (s_valid && s_ready && single) || (p_valid && p_ready));
    row_done = pop;
  end

  always_ff @(posedge clk)
    if (wr_ok) begin
      mem_flag[wr_ptr] <= wr_flag;
      mem_data[wr_ptr] <= wr_data;
    end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      row_flag <= '0;
      row_data <= '0;
      row_nnz <= '0;
      mask <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
      mask <= '0;
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      if (wr_ok) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) rd_ptr <= rd_ptr + ADDR_W'(1);
      count <= count + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop);
      if (state == IDLE && !empty) begin
        row_flag <= mem_flag[rd_ptr];
        row_data <= mem_data[rd_ptr];
        row_nnz <= (IDX_W+1)'(popcount(MAX_NCH'(mem_flag[rd_ptr])));
      end
      if (state == LOAD) mask <= row_flag;
      else if (s_valid && s_ready) mask <= mask & ~clr;
    end
endmodule

// File: tb/tb_act_fetch_unit.sv
// tb_act_fetch_unit: table-driven and scoreboard bench for act_fetch_unit
module tb_act_fetch_unit;
  localparam int DATA_W = 8;
  localparam int NCH = 16;
  localparam int DEPTH = 32;
  localparam int IDX_W = 4;
  localparam int DW = NCH * DATA_W;

  logic clk = 0, reset = 0, clear = 0, mode = 0, wr_en = 0, s_ready = 0, p_ready = 0;
  logic [NCH-1:0] wr_flag = '0;
  logic [DW-1:0] wr_data = '0;
  logic full, empty, overflow, s_valid, s_last, p_valid, row_done;
  logic [DATA_W-1:0] s_data;
  logic [IDX_W-1:0] s_idx;
  logic [DW-1:0] p_data;
  logic [NCH-1:0] p_flag;
  logic [IDX_W:0] row_nnz;

  act_fetch_unit #(.DATA_W(DATA_W), .NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .clear(clear), .mode(mode),
    .wr_en(wr_en), .wr_flag(wr_flag), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_idx(s_idx), .s_last(s_last),
    .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data), .p_flag(p_flag),
    .row_nnz(row_nnz), .row_done(row_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic m;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] d;
    logic last;
    logic [NCH-1:0] f;
    logic [DW-1:0] pd;
  } exp_t;

  typedef struct {
    logic m;
    logic [NCH-1:0] f;
    logic [7:0] seed;
    logic [IDX_W:0] nnz;
  } vec_t;

  exp_t sbq[$];
  int hs_p[$];
  vec_t vecs[7];
  int n_chk = 0, n_fail = 0, cyc = 0, hs_s = 0, rd_cnt = 0;
  logic prev_s_stall = 0, prev_p_stall = 0;
  logic [IDX_W-1:0] held_idx;
  logic [DATA_W-1:0] held_data;
  logic [DW-1:0] held_pd;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  function automatic logic [DW-1:0] make_data(input logic [7:0] seed);
    logic [DW-1:0] d;
    for (int i = 0; i < NCH; i++) d[i*DATA_W +: DATA_W] = seed + 8'(i);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic m, input logic [NCH-1:0] f, input logic [DW-1:0] d);
    exp_t e;
    e = '{m: m, idx: '0, d: '0, last: 1'b0, f: f, pd: d};
    if (m) sbq.push_back(e);
    else
      for (int i = 0; i < NCH; i++)
        if (f[i]) begin
          e.idx = IDX_W'(i);
          e.d = d[i*DATA_W +: DATA_W];
          e.last = (f >> (i + 1)) == '0;
          sbq.push_back(e);
        end
  endtask

  task automatic write_row(input logic [NCH-1:0] f, input logic [DW-1:0] d, input bit push);
    wr_en = 1;
    wr_flag = f;
    wr_data = d;
    if (push) push_row(mode, f, d);
    tick();
    wr_en = 0;
  endtask

  task automatic drain(input string nm);
    int i;
    i = 0;
    while (i < 600 && !(sbq.size() == 0 && empty && !s_valid && !p_valid)) begin
      tick();
      i++;
    end
    check(nm, 128'(i < 600), 1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_s_valid"}, s_valid, 0);
    check({tag, "_p_valid"}, p_valid, 0);
    check({tag, "_s_last"}, s_last, 0);
    check({tag, "_row_done"}, row_done, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_s_data"}, s_data, 0);
    check({tag, "_s_idx"}, s_idx, 0);
    check({tag, "_p_data"}, p_data, 0);
    check({tag, "_p_flag"}, p_flag, 0);
    check({tag, "_row_nnz"}, row_nnz, 0);
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (prev_s_stall) begin
      check("s_hold_valid", s_valid, 1);
      check("s_hold_idx", s_idx, held_idx);
      check("s_hold_data", s_data, held_data);
    end
    if (prev_p_stall) begin
      check("p_hold_valid", p_valid, 1);
      check("p_hold_data", p_data, held_pd);
    end
    if (s_valid && s_ready) begin
      hs_s++;
      check("s_expected", 128'(sbq.size() != 0 && !sbq[0].m), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("s_idx", s_idx, e.idx);
        check("s_data", s_data, e.d);
        check("s_last", s_last, e.last);
      end
    end
    if (p_valid && p_ready) begin
      hs_p.push_back(cyc);
      check("p_expected", 128'(sbq.size() != 0 && sbq[0].m), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("p_data", p_data, e.pd);
        check("p_flag", p_flag, e.f);
      end
    end
    if (row_done) rd_cnt++;
    prev_s_stall = s_valid && !s_ready && !clear && reset;
    prev_p_stall = p_valid && !p_ready && !clear && reset;
    held_idx = s_idx;
    held_data = s_data;
    held_pd = p_data;
  end

  initial begin
    int rd0, hs0, c0;
    vecs[0] = '{1'b0, 16'h8421, 8'h01, 5'd4};
    vecs[1] = '{1'b0, 16'h0000, 8'h09, 5'd0};
    vecs[2] = '{1'b0, 16'h0002, 8'h20, 5'd1};
    vecs[3] = '{1'b0, 16'hFFFF, 8'h40, 5'd16};
    vecs[4] = '{1'b1, 16'h1234, 8'h80, 5'd5};
    vecs[5] = '{1'b0, 16'h8000, 8'h11, 5'd1};
    vecs[6] = '{1'b1, 16'h0000, 8'h33, 5'd0};

    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst");
    reset = 1;
    tick();

    for (int v = 0; v < 7; v++) begin
      mode = vecs[v].m;
      s_ready = 1;
      p_ready = 1;
      rd0 = rd_cnt;
      write_row(vecs[v].f, make_data(vecs[v].seed), 1);
      tick();
      check("load_nnz", row_nnz, vecs[v].nnz);
      check("load_done", row_done, 128'(!vecs[v].m && vecs[v].nnz == 0));
      drain("vec_drain");
      check("row_done_cnt", rd_cnt - rd0, 1);
    end

    hs0 = hs_s;
    mode = 0;
    s_ready = 1;
    write_row(16'h00F0, make_data(8'h60), 1);
    for (int k = 0; k < 60 && !(sbq.size() == 0 && empty && !s_valid); k++) begin
      s_ready = (k % 3) == 0;
      tick();
    end
    s_ready = 1;
    drain("bp_drain");
    check("bp_handshakes", hs_s - hs0, 4);

    mode = 1;
    p_ready = 1;
    hs_p.delete();
    c0 = cyc;
    write_row(16'hA5A5, make_data(8'h05), 1);
    check("lat_empty", empty, 0);
    write_row(16'h0F0F, make_data(8'h50), 1);
    write_row(16'h3C3C, make_data(8'hA0), 1);
    drain("dense_drain");
    check("dense_hs_n", hs_p.size(), 3);
    if (hs_p.size() == 3) begin
      check("dense_hs0", hs_p[0], c0 + 3);
      check("dense_hs1", hs_p[1], c0 + 6);
      check("dense_hs2", hs_p[2], c0 + 9);
    end

    mode = 0;
    s_ready = 0;
    for (int k = 0; k < DEPTH; k++) write_row(16'h1 << (k % NCH), make_data(8'(k)), 1);
    check("fill_full", full, 1);
    check("fill_no_ovf", overflow, 0);
    write_row(16'hFFFF, make_data(8'hEE), 0);
    check("ovf_set", overflow, 1);
    check("ovf_full", full, 1);
    s_ready = 1;
    drain("fill_drain");
    check("ovf_sticky", overflow, 1);
    s_ready = 0;
    write_row(16'h0011, make_data(8'h70), 0);
    write_row(16'h0022, make_data(8'h71), 0);
    clear = 1;
    write_row(16'h0044, make_data(8'h72), 0);
    clear = 0;
    check("clr_empty", empty, 1);
    check("clr_ovf", overflow, 0);
    check("clr_full", full, 0);
    check("clr_s_valid", s_valid, 0);
    repeat (5) tick();
    check("clr_idle_s", s_valid, 0);
    check("clr_idle_e", empty, 1);

    s_ready = 1;
    hs0 = hs_s;
    write_row(16'hFFFF, make_data(8'h90), 1);
    for (int k = 0; k < 100 && hs_s < hs0 + 5; k++) tick();
    check("pre_rst_hs", hs_s - hs0, 5);
    reset = 0;
    #1;
    check_reset_state("mid_rst");
    sbq.delete();
    tick();
    tick();
    reset = 1;
    hs0 = hs_s;
    repeat (10) tick();
    check("post_rst_hs", hs_s - hs0, 0);
    check("post_rst_valid", s_valid, 0);
    write_row(16'h0104, make_data(8'hC0), 1);
    drain("post_rst_drain");
    check("post_rst_hs2", hs_s - hs0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
